rr_mux_select_arbiter: RTL
==========================

Name: rr_mux_select_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 multiplexer.
- Four sources raise requests. The block grants one source at a time and drives the mux 2-bit select so that the granted source's bit reaches the mux output.
- A grant is held until the source signals Done, drops its request, or exceeds a maximum hold time.
- Releases re-arbitrate back-to-back, with no idle bubble.

Parameters:
- MAX_HOLD, default 8: maximum consecutive cycles a single grant may be held. Legal range is 1 to 255.
- CNT_W, default 8: width of the internal hold counter. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- Req  input  [3:0]  request vector; bit i high means source i wants the mux.
- Done  input  1  the current grantee has finished; ignored while Grant_Valid=0.
- Select_Line  output  [1:0]  select driven into the 4:1 mux; equals the granted index.
- Grant  output  [3:0]  one-hot grant vector; 0000 when idle.
- Grant_Valid  output  1  a grant is active and Select_Line is meaningful.
- Timeout  output  1  one-cycle pulse when a grant was forcibly revoked by MAX_HOLD.

Behaviour:
- Single clock domain; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - Select_Line=00, Grant=0000, Grant_Valid=0, Timeout=0.
  - Internal pointer Ptr=0, Hold_Cnt=0, state IDLE.
- Reset asserted mid-grant: all of the above take effect at the next edge; any pending Done is discarded.
- Arbitration function:
  - Search Req starting at index Ptr, then Ptr+1, Ptr+2, Ptr+3, modulo 4.
  - The first set bit wins. Its index idx is registered into Select_Line, and Grant is set to one-hot(idx).
- IDLE state:
  - At an edge where Req!=0000: Grant_Valid=1 and Grant/Select_Line=idx, effective from that edge.
  - Latency is one cycle from Req first sampled high to grant visible. Hold_Cnt is cleared and the state moves to GRANT.
  - If Req=0000, stay in IDLE.
- GRANT state, evaluated at each edge with current grantee g:
  - Release conditions, in priority order:
    1. Done=1.
    2. Req[g]=0, the requester dropped.
    3. Hold_Cnt==MAX_HOLD-1, a timeout.
  - With no release: Hold_Cnt increments, and Select_Line/Grant are held stable.
  - On release: Ptr becomes g+1 mod 4, and arbitration runs in the same edge over the current Req with the new Ptr.
    - If a winner exists: grant it immediately (back-to-back), clear Hold_Cnt, stay in GRANT.
    - The released source is eligible but is now lowest priority.
    - If no winner: Grant_Valid=0, Grant=0000, go to IDLE.
- Timeout:
  - Asserted for exactly the one cycle following a timeout release.
  - Not asserted if Done or a Req drop coincides with the timeout edge; those take priority.
- Select_Line holds its last value while Grant_Valid=0; consumers must qualify it with Grant_Valid.
- Grant is always one-hot or zero. Grant_Valid equals the OR of Grant.
- Done while in IDLE has no effect.
- Req changes on non-granted bits during a grant have no effect until the next release.
- MAX_HOLD=1 means every grant lasts one cycle; round-robin then rotates every cycle when Req=1111.

Test Plan:
1. Reset: rst=1 for 2 cycles with Req=1111 and Done=1 -> Grant_Valid=0, Grant=0000, Select_Line=00, Timeout=0. After rst falls, first grant to index 0 at the next edge.
2. Single request: Req=0100 -> next cycle Grant=0100, Select_Line=10, Grant_Valid=1. Then Done=1 with Req=0000 in the same cycle -> following cycle Grant_Valid=0, Grant=0000, Select_Line stays 10.
3. Round-robin fairness: Req=1111 held, Done pulsed one cycle in every 3 -> grant sequence 0,1,2,3,0, each held 3 cycles, with no idle cycle between grants.
4. Timeout with MAX_HOLD=8:
   - Req=0011 held, Done=0 -> source 0 granted for exactly 8 cycles.
   - Then Grant switches to 0010 and Timeout=1 for 1 cycle.
   - Then source 1 is revoked after 8 cycles and source 0 is regranted.
5. Requester drop: source 3 granted (Req=1000), then Req=0000 with Done=0 after 2 cycles -> Grant_Valid=0 at the next edge, Timeout stays 0. Then Req=0001 -> granted 0 (Ptr wrapped to 0).
6. Reset mid-grant: source 2 granted with Hold_Cnt=5, assert rst for 1 cycle -> all outputs return to reset values. Then Req=0110 -> grant to 1 (Ptr reset to 0, not 3).

Source files
------------

// File: rtl/rr_mux_select_arbiter.sv
// Round-robin arbiter for four sources that drives the 2-bit select of a downstream 4:1 mux.
// Latency: a grant appears one cycle after the request is sampled, and a release re-grants in the same edge.
// Backpressure: a grant is held until Done, a request drop, or MAX_HOLD cycles; other requests wait their turn.
module rr_mux_select_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Req,
    input  logic       Done,
    output logic [1:0] Select_Line,
    output logic [3:0] Grant,
    output logic       Grant_Valid,
    output logic       Timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_q, hold_d;
    logic [1:0]         sel_q, sel_d;
    logic [3:0]         grant_q, grant_d;
    logic               gv_q, gv_d;
    logic               to_q, to_d;

    logic [1:0]         g;
    logic               rel_done, rel_drop, rel_to;
    logic [2:0]         pick_idle, pick_rel;

    // Returns {found, index} of the first set request at or after ptr, modulo 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx, cand;
        found = 1'b0;
        idx   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    assign g         = sel_q;
    assign rel_done  = Done;
    assign rel_drop  = !Req[g];
    assign rel_to    = (hold_q == CNT_W'(MAX_HOLD - 1));
    assign pick_idle = rr_pick(Req, ptr_q);
    assign pick_rel  = rr_pick(Req, g + 2'd1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_idle[2]) begin
                    sel_d   = pick_idle[1:0];
                    grant_d = 4'b0001 << pick_idle[1:0];
                    gv_d    = 1'b1;
                    hold_d  = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_to) begin
                    ptr_d = g + 2'd1;
                    // Done and a request drop outrank the timeout, so no pulse then.
                    to_d  = rel_to && !rel_done && !rel_drop;
                    if (pick_rel[2]) begin
                        sel_d   = pick_rel[1:0];
                        grant_d = 4'b0001 << pick_rel[1:0];
                        hold_d  = '0;
                    end else begin
                        grant_d = 4'b0000;
                        gv_d    = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            hold_q  <= '0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            gv_q    <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
            to_q    <= to_d;
        end
    end

    assign Select_Line = sel_q;
    assign Grant       = grant_q;
    assign Grant_Valid = gv_q;
    assign Timeout     = to_q;

endmodule
